// File: rtl/results_pkg.sv
// -----------------------------------------------------------------------------
// results_pkg
// Shared defaults for the result capture FIFO slice.
//   DATA_W_DEF  : result word width (6-bit arithmetic stage result)
//   DEPTH_DEF   : FIFO entry count (power of two, >= 2)
//   CNT_W_DEF   : overflow event counter width
//   ENTRY_W_DEF : stored record width, {overflow, data}
// Optional feature macro used by the slice: RESULT_FIFO_OVF_CNT_EN.
// -----------------------------------------------------------------------------
package results_pkg;

    localparam int unsigned DATA_W_DEF  = 6;
    localparam int unsigned DEPTH_DEF   = 4;
    localparam int unsigned CNT_W_DEF   = 8;
    localparam int unsigned ENTRY_W_DEF = DATA_W_DEF + 1;

    // Stored record is the overflow flag prepended to the data word.
    function automatic int unsigned entry_w(input int unsigned data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/result_capture_fifo_if.sv
// -----------------------------------------------------------------------------
// result_capture_fifo_if
// Bundles the upstream/downstream handshake signals of result_capture_fifo.
// Signal names match the FIFO port names so the bundle connects 1:1.
//   i_data/i_overflow/i_valid : upstream result word, flag and strobe
//   o_ready                   : space available
//   o_data/o_overflow/o_valid : head entry and its valid
//   i_ready                   : downstream accepts head
//   o_count                   : occupancy
//   o_drop                    : registered drop pulse
//   o_ovf_cnt                 : overflow counter (only with RESULT_FIFO_OVF_CNT_EN)
// Modports: master = producer/consumer side, slave = FIFO side.
// -----------------------------------------------------------------------------
interface result_capture_fifo_if #(
    parameter int unsigned DATA_W = results_pkg::DATA_W_DEF,
    parameter int unsigned DEPTH  = results_pkg::DEPTH_DEF,
    parameter int unsigned CNT_W  = results_pkg::CNT_W_DEF
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] i_data;
    logic              i_overflow;
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] o_data;
    logic              o_overflow;
    logic              o_valid;
    logic              i_ready;
    logic [CW-1:0]     o_count;
    logic              o_drop;
`ifdef RESULT_FIFO_OVF_CNT_EN
    logic [CNT_W-1:0]  o_ovf_cnt;
`endif

    modport master (
        output i_data, i_overflow, i_valid, i_ready,
        input  o_ready, o_data, o_overflow, o_valid, o_count, o_drop
`ifdef RESULT_FIFO_OVF_CNT_EN
        , input o_ovf_cnt
`endif
    );

    modport slave (
        input  i_data, i_overflow, i_valid, i_ready,
        output o_ready, o_data, o_overflow, o_valid, o_count, o_drop
`ifdef RESULT_FIFO_OVF_CNT_EN
        , output o_ovf_cnt
`endif
    );

endinterface

// File: rtl/result_fifo_mem.sv
// -----------------------------------------------------------------------------
// result_fifo_mem
// DEPTH x ENTRY_W storage, one synchronous write port and one asynchronous
// read port. Contents are not reset; validity is tracked by the controller.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write record
//   raddr_i : read address
//   rdata_o : read record (combinational)
// -----------------------------------------------------------------------------
module result_fifo_mem #(
    parameter int unsigned ENTRY_W = results_pkg::ENTRY_W_DEF,
    parameter int unsigned DEPTH   = results_pkg::DEPTH_DEF,
    parameter int unsigned AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/result_capture_fifo.sv
// -----------------------------------------------------------------------------
// result_capture_fifo
// Captures {overflow, data} result words from the arithmetic stage into a
// small power-of-two FIFO. No fall-through and no write bypass when full:
// a word offered while full is discarded and flagged on o_drop one cycle later.
//   clk        : clock, rising edge
//   i_rst_n    : asynchronous active-low reset
//   i_data     : result word          i_overflow : its overflow flag
//   i_valid    : upstream word present
//   o_ready    : not full
//   o_data     : head data            o_overflow : head overflow flag
//   o_valid    : not empty
//   i_ready    : downstream takes head
//   o_count    : occupancy, 0..DEPTH
//   o_drop     : registered pulse for a discarded word
//   o_ovf_cnt  : saturating count of accepted overflow words
//                (present only when RESULT_FIFO_OVF_CNT_EN is defined)
// -----------------------------------------------------------------------------
module result_capture_fifo
    import results_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_overflow,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_overflow,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_drop
`ifdef RESULT_FIFO_OVF_CNT_EN
    ,
    output logic [CNT_W-1:0]         o_ovf_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = entry_w(DATA_W);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("result_capture_fifo: DEPTH must be a power of two >= 2");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          drop_q, drop_d;
    logic          full, empty, wr_en, rd_en;
    logic [EW-1:0] rd_entry;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // Full-ness is judged on the registered count, so a same-cycle read
    // never frees a slot for the incoming word.
    assign wr_en = i_valid && !full;
    assign rd_en = i_ready && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = i_valid && full;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    result_fifo_mem #(
        .ENTRY_W (EW),
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i ({i_overflow, i_data}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    assign o_ready                = !full;
    assign o_valid                = !empty;
    assign o_count                = count_q;
    assign o_drop                 = drop_q;
    assign {o_overflow, o_data}   = rd_entry;

`ifdef RESULT_FIFO_OVF_CNT_EN
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (wr_en && i_overflow && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign o_ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_result_capture_fifo.sv
// -----------------------------------------------------------------------------
// tb_result_capture_fifo
// Self-checking bench for result_capture_fifo: a queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
// Honours RESULT_FIFO_OVF_CNT_EN for the overflow counter checks.
// -----------------------------------------------------------------------------
module tb_result_capture_fifo;

    localparam int unsigned DW    = results_pkg::DATA_W_DEF;
    localparam int unsigned DEPTH = results_pkg::DEPTH_DEF;
    localparam int unsigned CNT_W = results_pkg::CNT_W_DEF;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic clk;
    logic rst_n;

    result_capture_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    result_capture_fifo #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .i_rst_n    (rst_n),
        .i_data     (bus.i_data),
        .i_overflow (bus.i_overflow),
        .i_valid    (bus.i_valid),
        .o_ready    (bus.o_ready),
        .o_data     (bus.o_data),
        .o_overflow (bus.o_overflow),
        .o_valid    (bus.o_valid),
        .i_ready    (bus.i_ready),
        .o_count    (bus.o_count),
        .o_drop     (bus.o_drop)
`ifdef RESULT_FIFO_OVF_CNT_EN
        ,
        .o_ovf_cnt  (bus.o_ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: queue of {overflow, data}, expected drop pulse and
    // unsaturated count of accepted overflow words.
    logic [DW:0] model_q[$];
    bit          drop_m = 1'b0;
    int          ovf_m  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        int sz;
        sz = model_q.size();
        chk("o_count", int'(bus.o_count), sz);
        chk("o_valid", int'(bus.o_valid), int'(sz != 0));
        chk("o_ready", int'(bus.o_ready), int'(sz < DEPTH));
        chk("o_drop",  int'(bus.o_drop),  int'(drop_m));
        if (sz != 0) begin
            chk("o_data",     int'(bus.o_data),     int'(model_q[0][DW-1:0]));
            chk("o_overflow", int'(bus.o_overflow), int'(model_q[0][DW]));
        end
`ifdef RESULT_FIFO_OVF_CNT_EN
        chk("o_ovf_cnt", int'(bus.o_ovf_cnt), (ovf_m > 255) ? 255 : ovf_m);
`endif
    endtask

    // Called just after a falling edge: drive inputs, advance model across
    // the next rising edge, then compare at the following falling edge.
    task automatic step(input bit v, input bit ov, input int d, input bit rdy);
        bit wr, rd;
        bus.i_valid    = v;
        bus.i_overflow = ov;
        bus.i_data     = DW'(d);
        bus.i_ready    = rdy;
        wr = v && (model_q.size() < DEPTH);
        rd = rdy && (model_q.size() > 0);
        drop_m = v && (model_q.size() == DEPTH);
        if (rd) void'(model_q.pop_front());
        if (wr) begin
            model_q.push_back({ov, DW'(d)});
            if (ov) ovf_m++;
        end
        @(negedge clk);
        compare();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic mid_reset();
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_o_valid", int'(bus.o_valid), 0);
        chk("rst_o_count", int'(bus.o_count), 0);
        chk("rst_o_ready", int'(bus.o_ready), 1);
        chk("rst_o_drop",  int'(bus.o_drop),  0);
        model_q.delete();
        drop_m = 1'b0;
        ovf_m  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        compare();
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_overflow = 1'b0;
        bus.i_data     = '0;
        bus.i_ready    = 1'b0;
        #1;
        chk("init_o_valid", int'(bus.o_valid), 0);
        chk("init_o_ready", int'(bus.o_ready), 1);
        chk("init_o_count", int'(bus.o_count), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        compare();

        // Single word, one-cycle latency; first edge after reset accepts it.
        step(1, 0, 5, 0);
        chk("lat_o_valid", int'(bus.o_valid), 1);
        chk("lat_o_data",  int'(bus.o_data),  5);
        chk("lat_o_count", int'(bus.o_count), 1);
        step(0, 0, 0, 1);
        chk("drain_o_count", int'(bus.o_count), 0);

        // Fill, then overflow offer.
        for (int i = 1; i <= 4; i++) step(1, 0, i, 0);
        chk("full_o_count", int'(bus.o_count), 4);
        chk("full_o_ready", int'(bus.o_ready), 0);
        step(1, 0, 9, 0);
        chk("drop_pulse",  int'(bus.o_drop),  1);
        chk("drop_o_data", int'(bus.o_data),  1);

        // Full with simultaneous offer and read: read only.
        step(1, 0, 7, 1);
        chk("nobypass_o_count", int'(bus.o_count), 3);
        chk("nobypass_o_drop",  int'(bus.o_drop),  1);
        chk("nobypass_o_data",  int'(bus.o_data),  2);
        step(0, 0, 0, 1);
        chk("seq_o_data_3", int'(bus.o_data), 3);
        chk("drop_cleared", int'(bus.o_drop), 0);
        step(0, 0, 0, 1);
        chk("seq_o_data_4", int'(bus.o_data), 4);
        step(0, 0, 0, 1);
        chk("empty_o_valid", int'(bus.o_valid), 0);
        step(0, 0, 0, 1);
        chk("empty_read_o_count", int'(bus.o_count), 0);

        // Steady state at count 2 across pointer wrap.
        step(1, 0, 10, 0);
        step(1, 0, 11, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 12 + i, 1);
            chk("steady_o_count", int'(bus.o_count), 2);
            chk("steady_o_data",  int'(bus.o_data),  11 + i);
        end

        // Reset with three entries present.
        step(1, 0, 40, 0);
        chk("pre_rst_o_count", int'(bus.o_count), 3);
        mid_reset();

`ifdef RESULT_FIFO_OVF_CNT_EN
        for (int i = 0; i < 4; i++) step(1, 0, i, 0);
        step(1, 1, 33, 0);
        chk("ovf_drop_not_counted", int'(bus.o_ovf_cnt), 0);
        for (int i = 0; i < 300; i++) step(1, 1, i % 64, 1);
        chk("ovf_saturated", int'(bus.o_ovf_cnt), 255);
        mid_reset();
        chk("ovf_reset", int'(bus.o_ovf_cnt), 0);
`endif

        // Randomized traffic with varying input/output pressure.
        for (int blk = 0; blk < 6; blk++) begin
            int pv, pr;
            pv = int'($urandom_range(10, 90));
            pr = int'($urandom_range(10, 90));
            for (int c = 0; c < 250; c++) begin
                bit v, ov, rdy;
                v   = ($urandom_range(0, 99) < pv);
                ov  = ($urandom_range(0, 3) == 0);
                rdy = ($urandom_range(0, 99) < pr);
                step(v, ov, int'($urandom_range(0, (1 << DW) - 1)), rdy);
            end
            if (blk == 2) mid_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
